// File: rtl/wb_retire_stage_pkg.sv
// Shared CSR constants for the retire stage: exception bit positions, ECODE/ESUBCODE
// values, FSM state type and the exception priority encoder.
package wb_retire_stage_pkg;

  // Bit positions inside the exception flag vector {ALE,BRK,SYS,INE,ADEF,INT}
  localparam int unsigned ExcInt  = 0;
  localparam int unsigned ExcAdef = 1;
  localparam int unsigned ExcIne  = 2;
  localparam int unsigned ExcSys  = 3;
  localparam int unsigned ExcBrk  = 4;
  localparam int unsigned ExcAle  = 5;

  localparam logic [5:0] EcodeInt  = 6'h00;
  localparam logic [5:0] EcodeAdef = 6'h08;
  localparam logic [5:0] EcodeAle  = 6'h09;
  localparam logic [5:0] EcodeSys  = 6'h0B;
  localparam logic [5:0] EcodeBrk  = 6'h0C;
  localparam logic [5:0] EcodeIne  = 6'h0D;

  localparam logic [8:0] EsubcodeNone = 9'h000;

  typedef enum logic [0:0] {StRun, StFlush} ws_state_e;

  // Highest-priority exception wins: INT > ADEF > INE > SYS > BRK > ALE
  function automatic logic [5:0] exc_ecode(input logic [5:0] flgs);
    if (flgs[ExcInt])  return EcodeInt;
    if (flgs[ExcAdef]) return EcodeAdef;
    if (flgs[ExcIne])  return EcodeIne;
    if (flgs[ExcSys])  return EcodeSys;
    if (flgs[ExcBrk])  return EcodeBrk;
    return EcodeAle;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order retire buffer: DEPTH entries of WIDTH bits, head is the oldest entry.
// clear empties the buffer and overrides any push in the same cycle.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents of empty slots are don't-care
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/wb_retire_stage.sv
// Write-back / retire stage: buffers upstream entries, retires the head one per cycle,
// reports exceptions and ertn, and discards younger work for FLUSH_CYC cycles afterwards.
module wb_retire_stage
  import wb_retire_stage_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned EXC_NUM   = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ms_to_ws_valid,
  output logic                   ws_allowin,
  input  logic [DATA_W-1:0]      ms_pc,
  input  logic [DATA_W-1:0]      ms_result,
  input  logic                   ms_gr_we,
  input  logic [4:0]             ms_dest,
  input  logic [EXC_NUM-1:0]     ms_exc_flgs,
  input  logic                   ms_inst_ertn,
  input  logic                   ms_csr_we,
  input  logic [13:0]            ms_csr_wnum,
  input  logic [DATA_W-1:0]      ms_csr_wmask,
  input  logic [DATA_W-1:0]      ms_csr_wdata,
  input  logic                   ws_stall,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [DATA_W-1:0]      debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [4:0]             debug_wb_rf_wnum,
  output logic [DATA_W-1:0]      debug_wb_rf_wdata,
  output logic                   csr_we,
  output logic [13:0]            csr_wnum,
  output logic [DATA_W-1:0]      csr_wmask,
  output logic [DATA_W-1:0]      csr_wval,
  output logic                   wb_exc,
  output logic [5:0]             wb_ecode,
  output logic [8:0]             wb_esubcode,
  output logic [DATA_W-1:0]      wb_pc,
  output logic [DATA_W-1:0]      wb_badvaddr,
  output logic                   ertn_flush,
  output logic                   ws_csr_blk,
  output logic [$clog2(DEPTH):0] ws_count
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned FlushW  = $clog2(FLUSH_CYC + 2);
  localparam int unsigned EntryW  = 4 * DATA_W + 1 + 5 + EXC_NUM + 1 + 1 + 14;

  ws_state_e         state_q;
  logic [FlushW-1:0] flush_cnt_q;
  logic [CW-1:0]     blk_cnt_q;

  logic [EntryW-1:0] push_data;
  logic [EntryW-1:0] head_data;
  logic [CW-1:0]     count;

  logic [DATA_W-1:0]  h_pc, h_result, h_csr_wmask, h_csr_wdata;
  logic               h_gr_we, h_ertn, h_csr_we;
  logic [4:0]         h_dest;
  logic [EXC_NUM-1:0] h_exc;
  logic [13:0]        h_csr_wnum;

  logic in_run, head_valid, retire, has_exc, flush_now, accept, push_blk, pop_blk;

  assign push_data = {ms_pc, ms_result, ms_gr_we, ms_dest, ms_exc_flgs, ms_inst_ertn,
                      ms_csr_we, ms_csr_wnum, ms_csr_wmask, ms_csr_wdata};
  assign {h_pc, h_result, h_gr_we, h_dest, h_exc, h_ertn,
          h_csr_we, h_csr_wnum, h_csr_wmask, h_csr_wdata} = head_data;

  assign in_run     = (state_q == StRun);
  assign head_valid = (count != '0);
  assign retire     = head_valid && !ws_stall && in_run;
  assign has_exc    = |h_exc;
  assign flush_now  = wb_exc || ertn_flush;
  // While flushing, the stage swallows everything offered to it
  assign ws_allowin = !in_run || (count < CW'(DEPTH)) || retire;
  assign accept     = ms_to_ws_valid && ws_allowin && in_run && !flush_now;
  assign push_blk   = accept && (ms_csr_we || ms_inst_ertn);
  assign pop_blk    = retire && (h_csr_we || h_ertn);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (flush_now),
    .push      (accept),
    .push_data (push_data),
    .pop       (retire),
    .head_data (head_data),
    .count     (count)
  );

  // Flush sequencing: a retiring exception/ertn opens a FLUSH_CYC-cycle discard window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (flush_now && (FLUSH_CYC != 0)) begin
            state_q     <= StFlush;
            flush_cnt_q <= FlushW'(FLUSH_CYC);
          end
        end
        StFlush: begin
          if (flush_cnt_q <= FlushW'(1)) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FlushW'(1);
          end
        end
        default: begin
          state_q     <= StRun;
          flush_cnt_q <= '0;
        end
      endcase
    end
  end

  // Number of buffered entries carrying csr_we or ertn; nonzero blocks upstream CSR reads
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blk_cnt_q <= '0;
    end else if (flush_now) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_q + CW'(push_blk) - CW'(pop_blk);
    end
  end

  assign rf_we             = retire && h_gr_we && !has_exc && !h_ertn;
  assign rf_waddr          = h_dest;
  assign rf_wdata          = h_result;
  assign debug_wb_pc       = h_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = h_dest;
  assign debug_wb_rf_wdata = h_result;

  assign csr_we    = retire && h_csr_we && !has_exc;
  assign csr_wnum  = h_csr_wnum;
  assign csr_wmask = h_csr_wmask;
  assign csr_wval  = h_csr_wdata;

  assign wb_exc      = retire && has_exc;
  assign wb_ecode    = exc_ecode(h_exc[5:0]);
  assign wb_esubcode = EsubcodeNone;
  assign wb_pc       = h_pc;
  // Fetch-address faults report the pc itself; everything else reports the computed address
  assign wb_badvaddr = (wb_ecode == EcodeAdef) ? h_pc : h_result;

  assign ertn_flush = retire && h_ertn && !has_exc;
  assign ws_csr_blk = (blk_cnt_q != '0);
  assign ws_count   = count;

endmodule

// File: doc/wb_retire_stage.md
WB_RETIRE_STAGE -- requirements
Module: wb_retire_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning retire-buffer entries (power of 2, 2..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning result/pc/CSR data width.
REQ-003 SHALL have parameter FLUSH_CYC, default 1, meaning cycles of input discard after a flush cycle.
REQ-004 SHALL have parameter EXC_NUM, default 6, meaning exception-flag vector width.
REQ-005 SHALL have ports, one per line, as follows.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ms_to_ws_valid  in  1  upstream entry valid.
- ws_allowin  out  1  entry accepted this cycle when high with ms_to_ws_valid.
- ms_pc / ms_result  in  DATA_W each  instruction pc; result or bad address.
- ms_gr_we, ms_dest  in  1, 5  GPR write enable and address.
- ms_exc_flgs  in  EXC_NUM  {ALE,BRK,SYS,INE,ADEF,INT}, bit 0 = INT.
- ms_inst_ertn  in  1  ertn instruction.
- ms_csr_we, ms_csr_wnum, ms_csr_wmask, ms_csr_wdata  in  1,14,DATA_W,DATA_W  CSR write request.
- ws_stall  in  1  blocks retirement this cycle.
- rf_we, rf_waddr, rf_wdata  out  1,5,DATA_W  GPR write port.
- debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata  out  DATA_W,4,5,DATA_W  trace.
- csr_we, csr_wnum, csr_wmask, csr_wval  out  1,14,DATA_W,DATA_W  CSR write port.
- wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_badvaddr  out  1,6,9,DATA_W,DATA_W  exception report.
- ertn_flush  out  1  ertn retired.
- ws_csr_blk  out  1  any valid buffered entry has csr_we or ertn.
- ws_count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-006 SHALL buffer accepted entries in an in-order FIFO of DEPTH; head = oldest.
REQ-007 SHALL drive ws_allowin = (count<DEPTH) or retire, where retire = head valid and not ws_stall and state RUN.
REQ-008 SHALL retire at most one entry per cycle; combinational outputs from head; zero added latency beyond one register stage (accept edge N, retire earliest cycle N+1).
REQ-009 SHALL assert rf_we = retire and gr_we and no exc flag and not ertn; debug_wb_rf_wen = {4{rf_we}}.
REQ-010 SHALL assert csr_we = retire and csr_we field and no exc flag.
REQ-011 SHALL assert wb_exc = retire and |exc_flgs, one cycle per excepting entry.
REQ-012 SHALL select ecode priority INT(0x00) > ADEF(0x08) > INE(0x0D) > SYS(0x0B) > BRK(0x0C) > ALE(0x09); wb_esubcode = 0.
REQ-013 SHALL drive wb_badvaddr = pc for ADEF, result otherwise.
REQ-014 SHALL assert ertn_flush = retire and ertn and no exc flag.
REQ-015 SHALL, on wb_exc or ertn_flush, empty FIFO at that edge, discard any entry accepted that cycle, enter FLUSH.
REQ-016 SHALL have states RUN, FLUSH; FLUSH holds ws_allowin=1, discards inputs, no retire, down-counter FLUSH_CYC; count 0 -> RUN.
REQ-017 SHALL, on simultaneous accept and retire at full, keep count unchanged; pointers wrap modulo DEPTH.
REQ-018 SHALL hold all outputs stable when ws_stall=1 except handshake; no retire-side effects while stalled.

Reset
REQ-019 SHALL on resetn low immediately: count=0, pointers=0, state RUN, counter 0; outputs rf_we, csr_we, wb_exc, ertn_flush, ws_csr_blk, debug_wb_rf_wen = 0; ws_allowin=1.
REQ-020 SHALL drop an in-flight flush when reset asserts mid-FLUSH.

Structure
REQ-021 SHALL take ECODE/ESUBCODE constants and exception bit indices from the shared csr package/header.
REQ-022 SHALL use one sub-module, wb_fifo (parametric DEPTH/width, with clear input).

Verification
REQ-023 Accept 3 entries, ws_stall=0, gr_we=1, dest 5/6/7 -> rf_we on three consecutive cycles, waddr 5,6,7 in order.
REQ-024 ws_stall=1 with DEPTH=2 -> ws_allowin=0 after 2 accepts; release -> one retire per cycle, order kept.
REQ-025 Head flags INT|ALE -> wb_exc=1, ecode 0x00, rf_we=0; younger entry discarded, ws_count=0 next cycle.
REQ-026 ADEF at pc 0x1c000003 -> ecode 0x08, badvaddr 0x1c000003; inputs discarded FLUSH_CYC cycles, then accepted.
REQ-027 Ertn with csr_we=1 -> ertn_flush=1, csr_we=1, ws_csr_blk=1 before retire, 0 after flush.
REQ-028 resetn low mid-FLUSH with 2 entries -> count=0, state RUN, all enables 0 asynchronously.
